// File: rtl/dual_port_ram_param.sv
// Parametrised true dual-port synchronous RAM with byte-lane writes,
// selectable same-port read-during-write, cross-port collision handling,
// optional output register and a power-on / on-demand clear sequencer.
module dual_port_ram_param #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       ADDR_W   = 6,
  parameter int unsigned       RDW_MODE = 0,
  parameter int unsigned       OUT_REG  = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  ready,
  input  logic                  en_a,
  input  logic                  wr_a,
  input  logic [DATA_W/8-1:0]   be_a,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [DATA_W-1:0]     data_a,
  output logic [DATA_W-1:0]     q_a,
  output logic                  rvalid_a,
  input  logic                  en_b,
  input  logic                  wr_b,
  input  logic [DATA_W/8-1:0]   be_b,
  input  logic [ADDR_W-1:0]     addr_b,
  input  logic [DATA_W-1:0]     data_b,
  output logic [DATA_W-1:0]     q_b,
  output logic                  rvalid_b,
  output logic                  coll
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned NBYTE = DATA_W/8;
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH-1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0]   q_a_q, q_a_d, q_b_q, q_b_d;
  logic                rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic                coll_q, coll_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_en_a, wr_en_b, same_addr;
  logic [NBYTE-1:0]    be_wa, be_wb;
  logic [DATA_W-1:0]   old_a, old_b, new_a, new_b;
  logic                rd_v_a, rd_v_b;
  logic [DATA_W-1:0]   rd_d_a, rd_d_b;
  logic                src_v_a, src_v_b;
  logic [DATA_W-1:0]   src_d_a, src_d_b;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] base,
                                              input logic [DATA_W-1:0] wdata,
                                              input logic [NBYTE-1:0]  be);
    logic [DATA_W-1:0] r;
    r = base;
    for (int unsigned i = 0; i < NBYTE; i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

  assign ready = (state_q == ST_READY);

  // Clear sequencer next state: sweep every word, then accept ports until clr
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + (ADDR_W+1)'(1);
        if (clr_addr_q == CLR_LAST) state_d = ST_READY;
      end
      ST_READY: begin
        if (clr) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Final post-write word seen at each port address: port B lanes first, port A on top,
  // so a single merged word serves both the array update and WRITE_FIRST read-back.
  always_comb begin
    wr_en_a   = ready & en_a & wr_a;
    wr_en_b   = ready & en_b & wr_b;
    same_addr = (addr_a == addr_b);
    be_wa     = wr_en_a ? be_a : '0;
    be_wb     = wr_en_b ? be_b : '0;
    old_a     = mem[addr_a];
    old_b     = mem[addr_b];
    new_a     = merge(merge(old_a, data_b, same_addr ? be_wb : '0), data_a, be_wa);
    new_b     = merge(merge(old_b, data_b, be_wb), data_a, same_addr ? be_wa : '0);
    rd_v_a    = ready & en_a & ~(wr_a & (RDW_MODE == 2));
    rd_v_b    = ready & en_b & ~(wr_b & (RDW_MODE == 2));
    rd_d_a    = (wr_a && RDW_MODE == 1) ? new_a : old_a;
    rd_d_b    = (wr_b && RDW_MODE == 1) ? new_b : old_b;
  end

  // Array update: clear sweep while not ready, otherwise the merged port writes
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[clr_addr_q[ADDR_W-1:0]] <= INIT_VAL;
    end else begin
      if (wr_en_b) mem[addr_b] <= new_b;
      if (wr_en_a) mem[addr_a] <= new_a;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic              s1_v_a_q, s1_v_a_d, s1_v_b_q, s1_v_b_d;
    logic [DATA_W-1:0] s1_d_a_q, s1_d_a_d, s1_d_b_q, s1_d_b_d;

    // Extra pipeline stage between array read and output registers
    always_comb begin
      s1_v_a_d = rd_v_a;
      s1_v_b_d = rd_v_b;
      s1_d_a_d = rd_v_a ? rd_d_a : s1_d_a_q;
      s1_d_b_d = rd_v_b ? rd_d_b : s1_d_b_q;
    end

    // Stage-1 registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_v_a_q <= 1'b0;
        s1_v_b_q <= 1'b0;
        s1_d_a_q <= '0;
        s1_d_b_q <= '0;
      end else begin
        s1_v_a_q <= s1_v_a_d;
        s1_v_b_q <= s1_v_b_d;
        s1_d_a_q <= s1_d_a_d;
        s1_d_b_q <= s1_d_b_d;
      end
    end

    assign src_v_a = s1_v_a_q;
    assign src_v_b = s1_v_b_q;
    assign src_d_a = s1_d_a_q;
    assign src_d_b = s1_d_b_q;
  end else begin : g_direct
    assign src_v_a = rd_v_a;
    assign src_v_b = rd_v_b;
    assign src_d_a = rd_d_a;
    assign src_d_b = rd_d_b;
  end

  // Output stage: q holds unless new read data arrives; collision flag is unpipelined
  always_comb begin
    q_a_d      = src_v_a ? src_d_a : q_a_q;
    q_b_d      = src_v_b ? src_d_b : q_b_q;
    rvalid_a_d = src_v_a;
    rvalid_b_d = src_v_b;
    coll_d     = ready & en_a & en_b & same_addr & (wr_a | wr_b);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      q_a_q      <= '0;
      q_b_q      <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      q_a_q      <= q_a_d;
      q_b_q      <= q_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      coll_q     <= coll_d;
    end
  end

  assign q_a      = q_a_q;
  assign q_b      = q_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign coll     = coll_q;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Testbench: three RAM instances (READ_FIRST/1-cycle, WRITE_FIRST/2-cycle,
// NO_CHANGE/1-cycle) share one stimulus stream and are compared each cycle
// against a word-array reference model.
module tb_dual_port_ram_param;

  localparam int NB    = 2;
  localparam int DEPTH = 64;
  localparam logic [15:0] INIT = 16'hE1E2;

  logic        clk, rst_n, clr;
  logic        en_a, wr_a, en_b, wr_b;
  logic [1:0]  be_a, be_b;
  logic [5:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;

  logic        ready_w    [3];
  logic        rvalid_a_w [3];
  logic        rvalid_b_w [3];
  logic        coll_w     [3];
  logic [15:0] q_a_w      [3];
  logic [15:0] q_b_w      [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    dual_port_ram_param #(
      .DATA_W  (16),
      .ADDR_W  (6),
      .RDW_MODE(k),
      .OUT_REG ((k == 1) ? 1 : 0),
      .INIT_VAL(INIT)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .ready   (ready_w[k]),
      .en_a    (en_a),
      .wr_a    (wr_a),
      .be_a    (be_a),
      .addr_a  (addr_a),
      .data_a  (data_a),
      .q_a     (q_a_w[k]),
      .rvalid_a(rvalid_a_w[k]),
      .en_b    (en_b),
      .wr_b    (wr_b),
      .be_b    (be_b),
      .addr_b  (addr_b),
      .data_b  (data_b),
      .q_b     (q_b_w[k]),
      .rvalid_b(rvalid_b_w[k]),
      .coll    (coll_w[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [15:0] mm [DEPTH];
  int          clear_left, clr_idx;
  logic        exp_ready, exp_coll;
  logic [15:0] eq_a [3], eq_b [3], pd_a [3], pd_b [3];
  logic        ev_a [3], ev_b [3], pv_a [3], pv_b [3];

  int total = 0;
  int bad   = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    clear_left = DEPTH;
    clr_idx    = 0;
    exp_ready  = 1'b0;
    exp_coll   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      eq_a[k] = '0; eq_b[k] = '0; pd_a[k] = '0; pd_b[k] = '0;
      ev_a[k] = 1'b0; ev_b[k] = 1'b0; pv_a[k] = 1'b0; pv_b[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk1 ($sformatf("ready%0d", k),    ready_w[k],    exp_ready);
      chk1 ($sformatf("coll%0d", k),     coll_w[k],     exp_coll);
      chk1 ($sformatf("rvalid_a%0d", k), rvalid_a_w[k], ev_a[k]);
      chk1 ($sformatf("rvalid_b%0d", k), rvalid_b_w[k], ev_b[k]);
      chk16($sformatf("q_a%0d", k),      q_a_w[k],      eq_a[k]);
      chk16($sformatf("q_b%0d", k),      q_b_w[k],      eq_b[k]);
    end
  endtask

  // One clock: predict from current inputs, clock, then compare every instance.
  task automatic cycle();
    logic [15:0] oa, ob, na, nb, da, db;
    logic        rdy, va, vb;
    oa = '0; ob = '0; na = '0; nb = '0;
    if (!rst_n) begin
      model_reset();
    end else begin
      rdy = (clear_left == 0);
      if (rdy) begin
        oa = mm[addr_a];
        ob = mm[addr_b];
        for (int i = 0; i < NB; i++) begin
          if (en_b && wr_b && be_b[i]) mm[addr_b][8*i +: 8] = data_b[8*i +: 8];
          if (en_a && wr_a && be_a[i]) mm[addr_a][8*i +: 8] = data_a[8*i +: 8];
        end
        na = mm[addr_a];
        nb = mm[addr_b];
        exp_coll = en_a && en_b && (addr_a == addr_b) && (wr_a || wr_b);
        if (clr) begin
          clear_left = DEPTH;
          clr_idx    = 0;
        end
      end else begin
        mm[clr_idx] = INIT;
        clr_idx++;
        clear_left--;
        exp_coll = 1'b0;
      end
      exp_ready = (clear_left == 0);
      for (int k = 0; k < 3; k++) begin
        va = rdy && en_a && !(wr_a && k == 2);
        vb = rdy && en_b && !(wr_b && k == 2);
        da = (wr_a && k == 1) ? na : oa;
        db = (wr_b && k == 1) ? nb : ob;
        if (k != 1) begin
          ev_a[k] = va; if (va) eq_a[k] = da;
          ev_b[k] = vb; if (vb) eq_b[k] = db;
        end else begin
          ev_a[k] = pv_a[k]; if (pv_a[k]) eq_a[k] = pd_a[k];
          ev_b[k] = pv_b[k]; if (pv_b[k]) eq_b[k] = pd_b[k];
          pv_a[k] = va; pd_a[k] = da;
          pv_b[k] = vb; pd_b[k] = db;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic port_a(input logic e, input logic w, input logic [1:0] be,
                        input logic [5:0] a, input logic [15:0] d);
    en_a = e; wr_a = w; be_a = be; addr_a = a; data_a = d;
  endtask

  task automatic port_b(input logic e, input logic w, input logic [1:0] be,
                        input logic [5:0] a, input logic [15:0] d);
    en_b = e; wr_b = w; be_b = be; addr_b = a; data_b = d;
  endtask

  task automatic idle();
    port_a(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
    port_b(1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
    clr = 1'b0;
  endtask

  task automatic rand_ports();
    port_a(1'($urandom), 1'($urandom), 2'($urandom),
           ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7)), 16'($urandom));
    port_b(1'($urandom), 1'($urandom), 2'($urandom),
           ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7)), 16'($urandom));
  endtask

  // Async reset: assert mid-cycle, check outputs immediately, hold n clocks.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < n; i++) cycle();
    rst_n = 1'b1;
  endtask

  // Run until ready rises (bounded) and return the number of clocks taken.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (ready_w[0] !== 1'b1 && n < 200);
  endtask

  int n;

  initial begin
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < DEPTH; i++) mm[i] = 'x;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // partial clear with port noise (ignored), then reset mid-clear
    for (int i = 0; i < 30; i++) begin
      rand_ports();
      clr = 1'($urandom);
      cycle();
    end
    idle();
    do_reset(2);
    wait_ready(n);
    chkint("clear_len_after_reset", n, DEPTH);

    // cleared contents visible one cycle after a read
    port_a(1'b1, 1'b0, 2'b00, 6'd0, 16'h0);
    cycle();
    chk16("init_word", q_a_w[0], INIT);
    chk1 ("init_rvalid", rvalid_a_w[0], 1'b1);

    // byte-lane merge
    idle();
    port_a(1'b1, 1'b1, 2'b11, 6'd5, 16'hAABB); cycle();
    port_a(1'b1, 1'b1, 2'b01, 6'd5, 16'h1122); cycle();
    idle();
    port_b(1'b1, 1'b0, 2'b00, 6'd5, 16'h0);    cycle();
    chk16("be_merge", q_b_w[0], 16'hAA22);

    // same-port read-during-write
    idle();
    port_a(1'b1, 1'b1, 2'b11, 6'd3, 16'h0010); cycle();
    port_a(1'b1, 1'b1, 2'b11, 6'd3, 16'h0055); cycle();
    chk16("rdw_read_first", q_a_w[0], 16'h0010);
    chk1 ("rdw_read_first_v", rvalid_a_w[0], 1'b1);
    chk16("rdw_no_change", q_a_w[2], 16'hE1E2);
    chk1 ("rdw_no_change_v", rvalid_a_w[2], 1'b0);
    idle(); cycle();
    chk16("rdw_write_first", q_a_w[1], 16'h0055);

    // write/write collision, full and partial lanes
    port_a(1'b1, 1'b1, 2'b11, 6'd9, 16'hA5A5);
    port_b(1'b1, 1'b1, 2'b11, 6'd9, 16'h5A5A); cycle();
    chk1("ww_coll", coll_w[0], 1'b1);
    idle();
    port_a(1'b1, 1'b0, 2'b00, 6'd9, 16'h0);    cycle();
    chk16("ww_a_wins", q_a_w[0], 16'hA5A5);
    port_a(1'b1, 1'b1, 2'b01, 6'd9, 16'h1111);
    port_b(1'b1, 1'b1, 2'b11, 6'd9, 16'h2222); cycle();
    idle();
    port_b(1'b1, 1'b0, 2'b00, 6'd9, 16'h0);    cycle();
    chk16("ww_lanes", q_b_w[0], 16'h2211);

    // write/read collision seen through the 2-cycle instance
    idle();
    port_a(1'b1, 1'b1, 2'b11, 6'd7, 16'h0001); cycle();
    port_a(1'b1, 1'b1, 2'b11, 6'd7, 16'hFFFF);
    port_b(1'b1, 1'b0, 2'b00, 6'd7, 16'h0);    cycle();
    chk1("wr_coll", coll_w[1], 1'b1);
    idle(); cycle();
    chk16("wr_pre_write", q_b_w[1], 16'h0001);
    chk1 ("wr_pre_write_v", rvalid_b_w[1], 1'b1);

    // randomized traffic with occasional clear requests
    for (int i = 0; i < 400; i++) begin
      rand_ports();
      clr = ($urandom_range(0, 149) == 0);
      cycle();
    end
    idle();
    wait_ready(n);

    // explicit clear request, then sweep all words on both ports
    clr = 1'b1; cycle();
    clr = 1'b0;
    wait_ready(n);
    chkint("clear_len_after_clr", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      port_a(1'b1, 1'b0, 2'b00, 6'(i), 16'h0);
      port_b(1'b1, 1'b0, 2'b00, 6'(DEPTH - 1 - i), 16'h0);
      cycle();
      chk16("clr_word", q_a_w[0], INIT);
    end
    idle(); cycle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
